conv_wb_addr: RTL and testbench

Write-back address generator for the convolution datapath, the writer counterpart of the kernel-read address generator. It accepts convolved output pixels over a valid/ready stream and assigns each a linear output-feature-map address (base + row·W + col). It buffers them in a 2-entry queue and issues single-word writes to the output memory, tolerating memory back-pressure. It sits between the MAC/accumulator output and the output-buffer SRAM write port, and reports row and frame completion to the top-level sequencer.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_wb_fifo.sv | 56 +++++
 rtl/conv_wb_addr.sv | 163 ++++++++++++++++
 tb/tb_conv_wb_addr.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution write-back path
package conv_pkg;

  // Write-back sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // Depth of the write-back queue between the result stream and the memory port
  localparam int WB_QDEPTH = 2;

  // Default field widths; users with other widths build their own entry type
  localparam int WB_ADDR_W = 18;
  localparam int WB_DATA_W = 16;

  // One pending memory write
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic                 row_end;
  } wb_entry_t;

endpackage

// File: rtl/conv_wb_fifo.sv
// rtl/conv_wb_fifo.sv - two-entry write-back queue with registered head
module conv_wb_fifo
  import conv_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t     mem [WB_QDEPTH];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;

  // A push into a full queue is only taken when the head leaves in the same cycle
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_wb_addr.sv
// rtl/conv_wb_addr.sv - output feature map write-back address generator
module conv_wb_addr
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int K_PARAMS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [K_PARAMS-1:0]   i_out_w,
  input  logic [K_PARAMS-1:0]   i_out_h,
  input  logic                  i_res_valid,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  output logic                  o_res_ready,
  input  logic                  i_mem_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_row_end,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int KW = K_PARAMS;

  // Entry type sized to this instance's widths
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          row_end;
  } wb_entry_p_t;

  wb_state_t   state;
  wb_state_t   state_nxt;
  logic [KW-1:0] w_q;
  logic [KW-1:0] h_q;
  logic [KW-1:0] col;
  logic [KW-1:0] row;
  logic [AW-1:0] ptr;

  logic        q_full;
  logic        q_empty;
  logic [1:0]  q_count;
  wb_entry_p_t q_head;
  wb_entry_p_t q_in;
  logic        q_pop;

  logic        start_ok;
  logic        start_zero;
  logic        accept;
  logic        col_last;
  logic        px_last;
  logic        drained;

  assign start_ok   = (state == IDLE) && i_start && (i_out_w != '0) && (i_out_h != '0);
  assign start_zero = (state == IDLE) && i_start && ((i_out_w == '0) || (i_out_h == '0));

  assign o_res_ready = (state == RUN) && !q_full;
  assign accept      = i_res_valid && o_res_ready;

  assign col_last = (col == w_q - KW'(1));
  assign px_last  = col_last && (row == h_q - KW'(1));

  assign q_in.addr    = ptr;
  assign q_in.data    = i_res_data;
  assign q_in.row_end = col_last;

  assign q_pop = o_we && i_mem_ready;

  // The queue is empty now, or its last entry leaves this cycle
  assign drained = q_empty || ((q_count == 2'd1) && q_pop);

  conv_wb_fifo #(
    .entry_t (wb_entry_p_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (q_in),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  assign o_we      = !q_empty;
  assign o_waddr   = q_head.addr;
  assign o_wdata   = q_head.data;
  assign o_row_end = o_we && q_head.row_end;
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = RUN;
        end else if (start_zero) begin
          state_nxt = DONE;
        end
      end
      RUN: begin
        if (accept && px_last) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (drained) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame dimensions, raster position and output address pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      h_q <= '0;
      col <= '0;
      row <= '0;
      ptr <= '0;
    end else if (start_ok) begin
      w_q <= i_out_w;
      h_q <= i_out_h;
      col <= '0;
      row <= '0;
      ptr <= i_base_addr;
    end else if (accept) begin
      ptr <= ptr + AW'(1);
      if (col_last) begin
        col <= '0;
        row <= row + KW'(1);
      end else begin
        col <= col + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_wb_addr.sv
// tb/tb_conv_wb_addr.sv - randomized self-checking bench for conv_wb_addr
module tb_conv_wb_addr;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [KW-1:0] i_out_w = '0;
  logic [KW-1:0] i_out_h = '0;
  logic          i_res_valid = 1'b0;
  logic [DW-1:0] i_res_data = '0;
  logic          o_res_ready;
  logic          i_mem_ready = 1'b1;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_row_end;
  logic          o_busy;
  logic          o_done;

  int checks = 0;
  int errors = 0;

  conv_wb_addr #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .K_PARAMS   (KW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_out_w     (i_out_w),
    .i_out_h     (i_out_h),
    .i_res_valid (i_res_valid),
    .i_res_data  (i_res_data),
    .o_res_ready (o_res_ready),
    .i_mem_ready (i_mem_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_row_end   (o_row_end),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(o_res_ready), 64'd0);
    chk({tag, "_we"},    64'(o_we),        64'd0);
    chk({tag, "_waddr"}, 64'(o_waddr),     64'd0);
    chk({tag, "_wdata"}, 64'(o_wdata),     64'd0);
    chk({tag, "_rowend"},64'(o_row_end),   64'd0);
    chk({tag, "_busy"},  64'(o_busy),      64'd0);
    chk({tag, "_done"},  64'(o_done),      64'd0);
  endtask

  // Pulse i_start for one cycle; returns at the negedge after the sampling edge
  task automatic pulse_start(input logic [AW-1:0] base, input int w, input int h);
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = base;
    i_out_w     = KW'(w);
    i_out_h     = KW'(h);
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  // Run a whole frame against a reference built from the raster rules:
  // pixel i goes to (base + i) mod 2^AW and ends a row when i mod W == W-1.
  task automatic run_frame(input string tag, input logic [AW-1:0] base, input int w, input int h,
                           input int valid_pct, input int mem_pct,
                           input int stall_at, input int stall_len, input int restart_cyc);
    logic [DW-1:0] dat [$];
    int total, sent, written, ndone, cyc, stall_left;
    logic drv_valid, drv_mem, ready_exp, we_exp, accept, wr;
    total = w * h;
    for (int i = 0; i < total; i++) dat.push_back(DW'($urandom));
    sent = 0; written = 0; ndone = 0; cyc = 0; stall_left = stall_len;
    i_res_valid = 1'b0;
    pulse_start(base, w, h);
    while (ndone == 0 && cyc < 400) begin
      drv_valid = ($urandom_range(99) < valid_pct);
      if (stall_left > 0 && written >= stall_at) begin
        drv_mem = 1'b0;
        stall_left--;
      end else begin
        drv_mem = ($urandom_range(99) < mem_pct);
      end
      i_res_valid = drv_valid;
      i_res_data  = (sent < total) ? dat[sent] : DW'($urandom);
      i_mem_ready = drv_mem;
      if (cyc == restart_cyc) begin
        i_start     = 1'b1;
        i_base_addr = AW'($urandom);
        i_out_w     = KW'(0);
        i_out_h     = KW'($urandom_range(5));
      end else begin
        i_start = 1'b0;
      end
      ready_exp = (sent < total) && ((sent - written) < 2);
      we_exp    = (written < sent);
      chk({tag, "_ready"}, 64'(o_res_ready), 64'(ready_exp));
      chk({tag, "_we"},    64'(o_we),        64'(we_exp));
      chk({tag, "_busy"},  64'(o_busy),      64'd1);
      chk({tag, "_done"},  64'(o_done),      64'(written == total));
      if (we_exp) begin
        chk({tag, "_waddr"},  64'(o_waddr),   64'((base + AW'(written)) & {AW{1'b1}}));
        chk({tag, "_wdata"},  64'(o_wdata),   64'(dat[written]));
        chk({tag, "_rowend"}, 64'(o_row_end), 64'((written % w) == (w - 1)));
      end
      accept = drv_valid && ready_exp;
      wr     = we_exp && drv_mem;
      if (written == total) ndone++;
      @(negedge clk);
      if (accept) sent++;
      if (wr) written++;
      cyc++;
    end
    i_start     = 1'b0;
    i_res_valid = 1'b0;
    i_mem_ready = 1'b1;
    chk({tag, "_finished"}, 64'(ndone), 64'd1);
    chk({tag, "_count"},    64'(written), 64'(total));
    chk({tag, "_busy_after"}, 64'(o_busy), 64'd0);
    chk({tag, "_done_after"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // W=3 H=2, stream and memory always ready
    run_frame("basic", AW'('h100), 3, 2, 100, 100, 0, 0, -1);

    // Same frame with a 4-cycle memory stall after the first write
    run_frame("stall", AW'('h100), 3, 2, 100, 100, 1, 4, -1);

    // Address wrap at the top of the address space
    run_frame("wrap", AW'('h3FFFE), 4, 1, 100, 100, 0, 0, -1);

    // Zero width and zero height frames
    pulse_start(AW'('h200), 0, 3);
    chk("zw_busy", 64'(o_busy), 64'd1);
    chk("zw_done", 64'(o_done), 64'd1);
    chk("zw_we",   64'(o_we),   64'd0);
    chk("zw_rdy",  64'(o_res_ready), 64'd0);
    @(negedge clk);
    chk("zw_busy2", 64'(o_busy), 64'd0);
    chk("zw_done2", 64'(o_done), 64'd0);
    chk("zw_we2",   64'(o_we),   64'd0);
    pulse_start(AW'('h200), 2, 0);
    chk("zh_done", 64'(o_done), 64'd1);
    chk("zh_we",   64'(o_we),   64'd0);
    @(negedge clk);
    chk("zh_busy2", 64'(o_busy), 64'd0);

    // Start pulse during RUN must be ignored
    run_frame("restart", AW'('h1230), 3, 3, 100, 100, 0, 0, 3);

    // Randomized frames with random valid and memory back-pressure
    for (int f = 0; f < 6; f++) begin
      run_frame("rand", AW'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 0,
                int'($urandom_range(0, 10)));
    end

    // Reset with two entries queued
    i_mem_ready = 1'b0;
    pulse_start(AW'('h2A0), 4, 2);
    i_res_valid = 1'b1;
    i_res_data  = DW'('hBEEF);
    repeat (2) @(negedge clk);
    chk("rq_we",    64'(o_we), 64'd1);
    chk("rq_ready", 64'(o_res_ready), 64'd0);
    chk("rq_addr",  64'(o_waddr), 64'('h2A0));
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    i_res_valid = 1'b0;
    i_mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_release");
    run_frame("after_rst", AW'('h055), 2, 2, 100, 100, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
